stepper_speed_ramp: RTL and testbench
=====================================

# stepper_speed_ramp

Parameterised step-rate generator for the stepper drive. It converts a run request, a speed level and a full/half-step mode into a step-period reload value and a single-cycle step tick. The speed level ramps one level at a time toward the target, and the block decelerates to the lowest level before stopping. It sits between the user speed/mode inputs and the phase sequencer, replacing the fixed six-entry combinational period select.

## Interface
- `CNT_W`, 21, width of the period count and `count_to`.
- `N_SPEEDS`, 6, number of speed levels (1..`N_SPEEDS`); level k runs at k × the base rate.
- `BASE_PERIOD`, 375000, full-step period of level 1 in clocks. Constraint: `BASE_PERIOD` ≥ 2·`N_SPEEDS`.
- `RAMP_STEPS`, 16, step ticks spent at each level during a ramp. Must be ≥ 1.
- `SEL_W`, 3, width of `speed_sel`. Must satisfy 2^`SEL_W` > `N_SPEEDS`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: level-sensitive run request.
- `step` in 1: 1 = full step, 0 = half step.
- `speed_sel` in `SEL_W`: requested level. Values 0 and >`N_SPEEDS` are treated as 1.
- `count_to` out `CNT_W`: active step period in clocks.
- `step_tick` out 1: one-cycle pulse per motor step.
- `cur_level` out `SEL_W`: current level; 0 when idle.
- `busy` out 1: high while not IDLE.
- `at_speed` out 1: running at the requested level.

## Operation
- Period table, evaluated at elaboration: P(k) = floor(`BASE_PERIOD`/k) for full step, floor(`BASE_PERIOD`/k) >> 1 for half step.
  - Table minimum is 1.
  - No runtime divider.
- Target level: tgt = `run` ? clamp(`speed_sel`) : 1.
- **IDLE state**
  - `cur_level` = 0, period counter held at 0, no ticks.
  - `run` = 1 sampled → RUN at the next edge with `cur_level` = 1, `count_to` = P(1, `step`), ramp counter = 0.
- **RUN state**
  - The period counter counts 0..`count_to`−1.
  - `step_tick` fires in the cycle the counter equals `count_to`−1; the counter returns to 0.
- **Ramp update, on each tick**
  - If `cur_level` == tgt: ramp counter cleared.
  - Else if ramp counter == `RAMP_STEPS`−1: `cur_level` ±1 toward tgt, ramp counter cleared.
  - Else: ramp counter +1.
- **Reload on each tick:** `count_to` reloads from P(next `cur_level`, `step`) on the same edge. Changes to `step` or `speed_sel` therefore apply only at tick boundaries; `count_to` never changes mid-period.
- **Stop:** a tick with `run` = 0 and `cur_level` == 1 is the last tick. The next state is IDLE, `cur_level` = 0, and `count_to` = P(1, `step`).
- **Re-assertion:** `run` re-asserted during deceleration resumes acceleration from the current level with no IDLE pass.
- **Target changes mid-ramp:** the new target is used from the next tick; the ramp counter is not reset.
- `at_speed` = RUN & `run` & (`cur_level` == clamp(`speed_sel`)). It is registered, updated on the tick edge.

## Timing
- Reset values: `count_to` = P(1, full) = `BASE_PERIOD`, `step_tick` = 0, `cur_level` = 0, `busy` = 0, `at_speed` = 0. State is IDLE, all counters 0.
- Start latency: the first `step_tick` occurs exactly `count_to` + 1 cycles after the edge on which `run` = 1 is sampled in IDLE.
- Tick spacing equals the `count_to` value loaded at the previous tick.
- `busy` rises on the IDLE→RUN edge and falls on the edge following the last tick.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronously), with no deceleration.
- A `run` pulse shorter than one clock that is not sampled by `clk` has no effect.

## Configuration
- `STEPPER_SPEED_RAMP_EN` defined: ramping and decelerated stop as described above.
- Not defined:
  - `cur_level` jumps directly to tgt at each tick; `RAMP_STEPS` is ignored.
  - A tick with `run` = 0 is the last tick regardless of level, so stop occurs at the next period boundary.
  - `at_speed` is high throughout RUN while `run` = 1.

## Test plan
Parameters for all scenarios: `BASE_PERIOD` = 12, `N_SPEEDS` = 6, `RAMP_STEPS` = 2, ramp enabled unless stated.
- Reset, then `run` = 1, `speed_sel` = 3, `step` = 1 → tick intervals 12, 12, 6, 6, 4, 4, …; `at_speed` rises on the 4th tick edge; `cur_level` = 3.
- At level 3, drop `run` → intervals 4, 4, 6, 6, 12, then `busy` = 0, `cur_level` = 0, no further ticks.
- Running at level 6 with full step, switch `step` to 0 mid-period → current interval unchanged at 2; next interval 1 (a tick every cycle); `count_to` = 1.
- `speed_sel` = 0 and `speed_sel` = 7 with `run` = 1 → runs at level 1, period 12, `at_speed` high after the first tick.
- `rst` low mid-ramp at level 2 → same cycle: `count_to` = 12, `cur_level` = 0, `busy` = 0; with `rst` released and `run` held, a restart from level 1.
- `STEPPER_SPEED_RAMP_EN` undefined, `speed_sel` = 4 → intervals 12, 3, 3, …; drop `run` → one more interval of 3, then IDLE.

Source files
------------

// File: rtl/stepper_speed_ramp_if.sv
// Control/status bundle between the speed/mode source and the step-rate generator.
interface stepper_speed_ramp_if #(
    parameter int CNT_W = 21,
    parameter int SEL_W = 3
);
    logic             run;
    logic             step;
    logic [SEL_W-1:0] speed_sel;
    logic [CNT_W-1:0] count_to;
    logic             step_tick;
    logic [SEL_W-1:0] cur_level;
    logic             busy;
    logic             at_speed;

    modport master (
        output run, step, speed_sel,
        input  count_to, step_tick, cur_level, busy, at_speed
    );

    modport slave (
        input  run, step, speed_sel,
        output count_to, step_tick, cur_level, busy, at_speed
    );
endinterface

// File: rtl/stepper_speed_ramp.sv
// Step-rate generator: turns run/speed/mode into a step period and a one-cycle step tick.
// Define STEPPER_SPEED_RAMP_EN for one-level-per-RAMP_STEPS ramping and decelerated stop.
module stepper_speed_ramp #(
    parameter int CNT_W       = 21,
    parameter int N_SPEEDS    = 6,
    parameter int BASE_PERIOD = 375000,
    parameter int RAMP_STEPS  = 16,
    parameter int SEL_W       = 3
) (
    input logic                 clk,
    input logic                 rst,
    stepper_speed_ramp_if.slave bus
);
    localparam int N_IDX = 2 ** SEL_W;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] count_to, count_to_n;
    logic [SEL_W-1:0] level, level_n;
    logic [SEL_W-1:0] sel_c, tgt;
    logic             hold, hold_n;
    logic             tick, stop;

`ifdef STEPPER_SPEED_RAMP_EN
    localparam int RW = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
    logic [RW-1:0] ramp, ramp_n;
    logic          at_speed, at_speed_n;
`endif

    logic [CNT_W-1:0] p_full [N_IDX];
    logic [CNT_W-1:0] p_half [N_IDX];

    // Out-of-range indices alias level 1 so any SEL_W-wide level indexes safely.
    for (genvar k = 0; k < N_IDX; k++) begin : g_tbl
        localparam int LVL = (k == 0 || k > N_SPEEDS) ? 1 : k;
        localparam int PF  = ((BASE_PERIOD / LVL) < 1) ? 1 : (BASE_PERIOD / LVL);
        localparam int PH  = ((PF >> 1) < 1) ? 1 : (PF >> 1);
        assign p_full[k] = CNT_W'(PF);
        assign p_half[k] = CNT_W'(PH);
    end

    function automatic logic [SEL_W-1:0] clamp_level(input logic [SEL_W-1:0] s);
        if (s == '0 || s > SEL_W'(N_SPEEDS)) return SEL_W'(1);
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            count_to <= CNT_W'(BASE_PERIOD);
            level    <= '0;
            hold     <= 1'b0;
`ifdef STEPPER_SPEED_RAMP_EN
            ramp     <= '0;
            at_speed <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            count_to <= count_to_n;
            level    <= level_n;
            hold     <= hold_n;
`ifdef STEPPER_SPEED_RAMP_EN
            ramp     <= ramp_n;
            at_speed <= at_speed_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        count_to_n = count_to;
        level_n    = level;
        hold_n     = 1'b0;
        tick       = 1'b0;
        stop       = 1'b0;
        sel_c      = clamp_level(bus.speed_sel);
        tgt        = bus.run ? sel_c : SEL_W'(1);
`ifdef STEPPER_SPEED_RAMP_EN
        ramp_n     = ramp;
        at_speed_n = at_speed;
`endif
        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_n    = RUN;
                    level_n    = SEL_W'(1);
                    count_to_n = bus.step ? p_full[1] : p_half[1];
                    cnt_n      = '0;
                    // One idle-count cycle gives the first period its extra clock.
                    hold_n     = 1'b1;
`ifdef STEPPER_SPEED_RAMP_EN
                    ramp_n     = '0;
`endif
                end
            end
            RUN: begin
                if (!hold && cnt == count_to - CNT_W'(1)) begin
                    tick  = 1'b1;
                    cnt_n = '0;
`ifdef STEPPER_SPEED_RAMP_EN
                    stop = !bus.run && (level == SEL_W'(1));
                    if (level == tgt) begin
                        ramp_n = '0;
                    end else if (ramp == RW'(RAMP_STEPS - 1)) begin
                        ramp_n  = '0;
                        level_n = (level < tgt) ? level + SEL_W'(1) : level - SEL_W'(1);
                    end else begin
                        ramp_n = ramp + RW'(1);
                    end
`else
                    stop    = !bus.run;
                    level_n = tgt;
`endif
                    if (stop) begin
                        state_n    = IDLE;
                        level_n    = '0;
                        count_to_n = bus.step ? p_full[1] : p_half[1];
                    end else begin
                        count_to_n = bus.step ? p_full[level_n] : p_half[level_n];
                    end
`ifdef STEPPER_SPEED_RAMP_EN
                    at_speed_n = !stop && bus.run && (level_n == sel_c);
`endif
                end else if (!hold) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.count_to  = count_to;
    assign bus.step_tick = tick;
    assign bus.cur_level = level;
    assign bus.busy      = (state == RUN);
`ifdef STEPPER_SPEED_RAMP_EN
    assign bus.at_speed  = at_speed;
`else
    assign bus.at_speed  = (state == RUN) && bus.run;
`endif
endmodule

// File: tb/tb_stepper_speed_ramp.sv
// Bench for stepper_speed_ramp: directed scenarios plus random run/speed/mode traffic,
// every cycle compared against a tick-event model of the step-rate rules.
module tb_stepper_speed_ramp;
    localparam int CNT_W       = 21;
    localparam int N_SPEEDS    = 6;
    localparam int BASE_PERIOD = 12;
    localparam int RAMP_STEPS  = 2;
    localparam int SEL_W       = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    stepper_speed_ramp_if #(.CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    stepper_speed_ramp #(
        .CNT_W(CNT_W), .N_SPEEDS(N_SPEEDS), .BASE_PERIOD(BASE_PERIOD),
        .RAMP_STEPS(RAMP_STEPS), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model state: m_left is the number of cycles up to and including the next tick cycle.
    int m_busy = 0, m_lvl = 0, m_ct = BASE_PERIOD, m_ramp = 0, m_left = 0, m_as = 0;
    int m_tgt, m_stop;

    function automatic int per(input int k, input logic full);
        int p;
        p = BASE_PERIOD / k;
        if (!full) p = p / 2;
        if (p < 1) p = 1;
        return p;
    endfunction

    function automatic int clampv(input int s);
        return (s == 0 || s > N_SPEEDS) ? 1 : s;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_busy = 0; m_lvl = 0; m_ct = BASE_PERIOD; m_ramp = 0; m_left = 0; m_as = 0;
        end else if (m_busy == 0) begin
            if (bus.run) begin
                m_busy = 1; m_lvl = 1; m_ramp = 0;
                m_ct   = per(1, bus.step);
                m_left = m_ct + 1;
            end
        end else if (m_left > 1) begin
            m_left--;
        end else begin
            m_tgt = bus.run ? clampv(int'(bus.speed_sel)) : 1;
`ifdef STEPPER_SPEED_RAMP_EN
            m_stop = (!bus.run && m_lvl == 1) ? 1 : 0;
            if (m_lvl == m_tgt) m_ramp = 0;
            else if (m_ramp == RAMP_STEPS - 1) begin
                m_lvl  = m_lvl + ((m_tgt > m_lvl) ? 1 : -1);
                m_ramp = 0;
            end else m_ramp++;
`else
            m_stop = bus.run ? 0 : 1;
            m_lvl  = m_tgt;
`endif
            if (m_stop != 0) begin
                m_busy = 0; m_lvl = 0; m_as = 0;
                m_ct   = per(1, bus.step);
            end else begin
                m_ct   = per(m_lvl, bus.step);
                m_left = m_ct;
                m_as   = (bus.run && m_lvl == clampv(int'(bus.speed_sel))) ? 1 : 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("step_tick", int'(bus.step_tick), (m_busy != 0 && m_left == 1) ? 1 : 0);
        chk("count_to", int'(bus.count_to), m_ct);
        chk("cur_level", int'(bus.cur_level), m_lvl);
        chk("busy", int'(bus.busy), m_busy);
`ifdef STEPPER_SPEED_RAMP_EN
        chk("at_speed", int'(bus.at_speed), m_as);
`else
        chk("at_speed", int'(bus.at_speed), (m_busy != 0 && bus.run) ? 1 : 0);
`endif
    end

    task automatic wait_tick(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.step_tick && n < limit);
    endtask

    task automatic no_tick(input int cycles, input string name);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.step_tick) seen++;
        end
        chk(name, seen, 0);
    endtask

`ifdef STEPPER_SPEED_RAMP_EN
    localparam int A_SEL = 3;
    int a_exp [6] = '{13, 12, 6, 6, 4, 4};
    int b_exp [5] = '{3, 4, 6, 6, 12};
`else
    localparam int A_SEL = 4;
    int a_exp [4] = '{13, 3, 3, 3};
    int b_exp [1] = '{2};
`endif

    initial begin
        int n, cyc;
        rst = 1'b0;
        bus.run = 1'b0; bus.step = 1'b1; bus.speed_sel = 3'd1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_count_to", int'(bus.count_to), 12);
        chk("rst_cur_level", int'(bus.cur_level), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_at_speed", int'(bus.at_speed), 0);
        chk("rst_step_tick", int'(bus.step_tick), 0);
        rst = 1'b1;

        // Ramp up from idle.
        @(negedge clk); #1;
        bus.run = 1'b1; bus.speed_sel = 3'(A_SEL); bus.step = 1'b1;
        foreach (a_exp[i]) begin
            wait_tick(n, 40);
            chk("ramp_up_interval", n, a_exp[i]);
        end
        chk("ramp_up_level", int'(bus.cur_level), A_SEL);
        chk("ramp_up_at_speed", int'(bus.at_speed), 1);

        // Drop run one cycle into a period and follow it down to idle.
        @(negedge clk); #1;
        bus.run = 1'b0;
        foreach (b_exp[i]) begin
            wait_tick(n, 40);
            chk("stop_interval", n, b_exp[i]);
        end
        @(negedge clk);
        chk("stop_busy", int'(bus.busy), 0);
        chk("stop_level", int'(bus.cur_level), 0);
        chk("stop_count_to", int'(bus.count_to), 12);
        no_tick(30, "idle_no_tick");

        // A run pulse that never meets a rising edge must be ignored.
        @(negedge clk); #1;
        bus.run = 1'b1; #2; bus.run = 1'b0;
        no_tick(5, "glitch_no_tick");
        chk("glitch_busy", int'(bus.busy), 0);

        // Out-of-range selects run at level 1.
        @(negedge clk); #1;
        bus.speed_sel = 3'd0; bus.step = 1'b1; bus.run = 1'b1;
        wait_tick(n, 40);
        chk("sel0_first_interval", n, 13);
        @(negedge clk);
        chk("sel0_at_speed", int'(bus.at_speed), 1);
        chk("sel0_level", int'(bus.cur_level), 1);
        chk("sel0_count_to", int'(bus.count_to), 12);
        #1 bus.speed_sel = 3'd7;
        wait_tick(n, 40);
        chk("sel7_partial", n, 11);
        wait_tick(n, 40);
        chk("sel7_interval", n, 12);
        chk("sel7_at_speed", int'(bus.at_speed), 1);

        // Top speed, then switch to half step mid-period.
        #1 bus.speed_sel = 3'd6;
        for (int i = 0; i < 60; i++) begin
            wait_tick(n, 40);
            if (bus.cur_level == 3'd6 && bus.count_to == 21'd2) break;
        end
        chk("reach_level6", int'(bus.cur_level), 6);
        @(negedge clk); #1;
        bus.step = 1'b0;
        wait_tick(n, 10);
        chk("half_switch_partial", n, 1);
        wait_tick(n, 10);
        chk("half_interval_a", n, 1);
        wait_tick(n, 10);
        chk("half_interval_b", n, 1);
        chk("half_count_to", int'(bus.count_to), 1);

        // Return to idle, restart toward level 2, and reset partway.
        #1 bus.run = 1'b0; bus.step = 1'b1;
        cyc = 0;
        while (bus.busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("decel_to_idle", int'(bus.busy), 0);
        @(negedge clk); #1;
        bus.run = 1'b1; bus.speed_sel = 3'd2;
        for (int i = 0; i < 10; i++) begin
            wait_tick(n, 40);
            if (bus.cur_level == 3'd2) break;
        end
        chk("reach_level2", int'(bus.cur_level), 2);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_count_to", int'(bus.count_to), 12);
        chk("async_rst_level", int'(bus.cur_level), 0);
        chk("async_rst_busy", int'(bus.busy), 0);
        chk("async_rst_tick", int'(bus.step_tick), 0);
        chk("async_rst_at_speed", int'(bus.at_speed), 0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("restart_busy", int'(bus.busy), 1);
        chk("restart_level", int'(bus.cur_level), 1);
        wait_tick(n, 40);
        chk("restart_interval", n, 12);

        // Random traffic, including sub-cycle run glitches and occasional async resets.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (!rst) rst = 1'b1;
            if ($urandom_range(0, 79) == 0) bus.run = ~bus.run;
            if ($urandom_range(0, 39) == 0) bus.speed_sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) bus.step = ~bus.step;
            if (!bus.run && $urandom_range(0, 99) == 0) begin
                bus.run = 1'b1; #1; bus.run = 1'b0;
            end else if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1'b0;
            end
        end
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
